huffman_table_loader: RTL and testbench
=======================================

Name: huffman_table_loader

Overview:
Builds the decode lookup table consumed by the stream decoder's table-write port (table_push/table_addr/table_code_width/table_data). Accepts (symbol, code length) pairs in canonical order and expands each into the 2^(MAX_CODE_LENGTH-len) left-aligned table entries it occupies, one write per cycle. It also fills unused entries and flags malformed or oversubscribed code sets. It sits between the control/header parser and the stream decoder.

Parameters:
WIDTH_OUT, 8, symbol width; matches decoder table_data
MAX_CODE_LENGTH, 9, longest code; table depth 2^MAX_CODE_LENGTH
LOG2_MAX_CODE_LENGTH, log2(MAX_CODE_LENGTH), width of length / code_width fields

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse that begins a table build
in_valid  input  1  symbol/length pair valid
in_ready  output  1  loader accepts pair this cycle
in_symbol  input  WIDTH_OUT  symbol value
in_length  input  LOG2_MAX_CODE_LENGTH  code length; 0 = symbol unused
in_last  input  1  final pair of the set
table_push  output  1  table write strobe
table_addr  output  MAX_CODE_LENGTH  write address
table_code_width  output  LOG2_MAX_CODE_LENGTH  code width written
table_data  output  WIDTH_OUT  symbol written
busy  output  1  build in progress
done  output  1  build finished cleanly; held until next start
incomplete  output  1  valid with done; code space not fully used
error  output  1  sticky until next start or reset

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low. On reset, all outputs are 0, state is IDLE, and next_addr is 0.
- States: IDLE, ACCEPT, WRITE, FILL, DONE, ERR.
- IDLE/DONE/ERR: a start pulse clears done, incomplete, error and next_addr (MAX_CODE_LENGTH+1 bits), then moves to ACCEPT. start is ignored in ACCEPT, WRITE and FILL.
- ACCEPT: in_ready=1. The handshake is in_valid & in_ready.
  - len=0: accepted with no writes. If in_last, go to FILL; otherwise stay in ACCEPT.
  - len>MAX_CODE_LENGTH: go to ERR.
  - len < last nonzero len: go to ERR (ordering violation).
  - next_addr + 2^(MAX-len) > 2^MAX: go to ERR (oversubscribed).
  - Otherwise latch symbol, len, span = 2^(MAX-len) and base = next_addr, then go to WRITE.
- WRITE: in_ready=0. Emits one write per cycle for span cycles.
  - Outputs are registered: table_push=1, table_addr = base+i, table_code_width=len, table_data=symbol.
  - The first write appears the cycle after the handshake.
  - After the last write, next_addr += span. If the pair had in_last, go to FILL; otherwise go to ACCEPT.
  - Maximum throughput is one pair per span+1 cycles.
- FILL: if next_addr == 2^MAX, go to DONE with incomplete=0. Otherwise write entries next_addr..2^MAX-1, one per cycle, with code_width=0 and data=0; then go to DONE with incomplete=1.
- ERR: no further table writes. error=1, in_ready=0. Pairs are not consumed.
- busy = 1 in ACCEPT, WRITE and FILL.
- table_addr: left-aligned code space. Address bit MAX-1 corresponds to the first stream bit of a code. Canonical ordering guarantees base is a multiple of span.
- table_push is 0 in every state other than WRITE and FILL. table_addr, table_code_width and table_data hold their last values when table_push=0.
- Reset mid-build: aborts immediately with no further writes. The partial table is not cleared; a new start is required.

Test Plan:
- Complete code, MAX=9, pairs A(0x41,len1), B(0x42,len2), C(0x43,len2,last) -> writes addr 0..255 (w=1, data 0x41), 256..383 (w=2, data 0x42), 384..511 (w=2, data 0x43); no FILL writes; done=1, incomplete=0, error=0; exactly 512 table_push cycles.
- Single pair (0x07, len1, last) -> addr 0..255 (w=1, data 0x07), then FILL writes 256..511 (w=0, data 0); done=1, incomplete=1.
- Oversubscription: three len1 pairs -> first two produce 256 writes each; third handshake -> error=1, no further writes, done=0.
- Ordering and range: len2 then len1 -> error after the second handshake. Any pair with len=10 -> error with no writes.
- len=0 skip plus backpressure: pairs (0x01, len0), (0x02, len9, last) with in_valid toggling -> in_ready=0 throughout WRITE; single write addr 0 (w=9, data 0x02); FILL writes 1..511.
- Reset and restart: assert rst low during the WRITE of a len1 symbol at i=100 -> table_push=0 and all outputs 0 asynchronously; a new start rebuilds cleanly from addr 0.

Source files
------------

// File: rtl/huffman_table_loader_if.sv
// Pair stream and decode-table write bus shared by the header parser,
// the table loader and the stream decoder's table-write port.
interface huffman_table_loader_if #(
    parameter int WIDTH_OUT            = 8,
    parameter int MAX_CODE_LENGTH      = 9,
    parameter int LOG2_MAX_CODE_LENGTH = $clog2(MAX_CODE_LENGTH + 1)
) ();
    logic                            in_valid;
    logic                            in_ready;
    logic [WIDTH_OUT-1:0]            in_symbol;
    logic [LOG2_MAX_CODE_LENGTH-1:0] in_length;
    logic                            in_last;

    logic                            table_push;
    logic [MAX_CODE_LENGTH-1:0]      table_addr;
    logic [LOG2_MAX_CODE_LENGTH-1:0] table_code_width;
    logic [WIDTH_OUT-1:0]            table_data;

    // Environment side: offers pairs and observes table writes.
    modport master (
        output in_valid, in_symbol, in_length, in_last,
        input  in_ready, table_push, table_addr, table_code_width, table_data
    );

    // Loader side: consumes pairs and produces table writes.
    modport slave (
        input  in_valid, in_symbol, in_length, in_last,
        output in_ready, table_push, table_addr, table_code_width, table_data
    );
endinterface

// File: rtl/huffman_table_loader.sv
// Expands canonical (symbol, length) pairs into a left-aligned decode table,
// one table write per cycle, padding unused entries and flagging bad code sets.
module huffman_table_loader #(
    parameter int WIDTH_OUT            = 8,
    parameter int MAX_CODE_LENGTH      = 9,
    parameter int LOG2_MAX_CODE_LENGTH = $clog2(MAX_CODE_LENGTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    huffman_table_loader_if.slave bus,
    output logic                  busy,
    output logic                  done,
    output logic                  incomplete,
    output logic                  error
);
    localparam int AW = MAX_CODE_LENGTH;
    localparam int LW = LOG2_MAX_CODE_LENGTH;

    // FULL is the code-space size; next_addr reaching it means every entry is written.
    localparam logic [AW:0]   FULL     = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   ONE      = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] MAX_LEN  = LW'(MAX_CODE_LENGTH);

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        WRITE,
        FILL,
        DONE,
        ERR
    } state_t;

    state_t        state;
    logic [AW:0]   next_addr;
    logic [AW:0]   wr_left;
    logic [LW-1:0] last_len;
    logic          last_q;
    logic          fill_active;

    logic [AW:0]   span_in;
    logic [AW:0]   end_in;

    // Entries covered by the offered pair and where its run would end.
    assign span_in = FULL >> bus.in_length;
    assign end_in  = next_addr + span_in;

    // Build sequencer; every output, including the table write port, is registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= IDLE;
            next_addr            <= '0;
            wr_left              <= '0;
            last_len             <= '0;
            last_q               <= 1'b0;
            fill_active          <= 1'b0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            incomplete           <= 1'b0;
            error                <= 1'b0;
            bus.in_ready         <= 1'b0;
            bus.table_push       <= 1'b0;
            bus.table_addr       <= '0;
            bus.table_code_width <= '0;
            bus.table_data       <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state        <= ACCEPT;
                        busy         <= 1'b1;
                        bus.in_ready <= 1'b1;
                        done         <= 1'b0;
                        incomplete   <= 1'b0;
                        error        <= 1'b0;
                        next_addr    <= '0;
                        last_len     <= '0;
                        fill_active  <= 1'b0;
                    end
                end

                ACCEPT: begin
                    if (bus.in_valid) begin
                        if (bus.in_length == '0) begin
                            if (bus.in_last) begin
                                state        <= FILL;
                                bus.in_ready <= 1'b0;
                            end
                        end else if ((bus.in_length > MAX_LEN) ||
                                     (bus.in_length < last_len) ||
                                     (end_in > FULL)) begin
                            state        <= ERR;
                            busy         <= 1'b0;
                            bus.in_ready <= 1'b0;
                            error        <= 1'b1;
                        end else begin
                            state                <= WRITE;
                            bus.in_ready         <= 1'b0;
                            last_len             <= bus.in_length;
                            last_q               <= bus.in_last;
                            wr_left              <= span_in - ONE;
                            bus.table_push       <= 1'b1;
                            bus.table_addr       <= next_addr[AW-1:0];
                            bus.table_code_width <= bus.in_length;
                            bus.table_data       <= bus.in_symbol;
                        end
                    end
                end

                WRITE: begin
                    if (wr_left == '0) begin
                        bus.table_push <= 1'b0;
                        next_addr      <= {1'b0, bus.table_addr} + ONE;
                        if (last_q) begin
                            state <= FILL;
                        end else begin
                            state        <= ACCEPT;
                            bus.in_ready <= 1'b1;
                        end
                    end else begin
                        wr_left        <= wr_left - ONE;
                        bus.table_addr <= bus.table_addr + ADDR_ONE;
                    end
                end

                FILL: begin
                    if (next_addr == FULL) begin
                        state          <= DONE;
                        bus.table_push <= 1'b0;
                        busy           <= 1'b0;
                        done           <= 1'b1;
                        incomplete     <= fill_active;
                        fill_active    <= 1'b0;
                    end else begin
                        bus.table_push       <= 1'b1;
                        bus.table_addr       <= next_addr[AW-1:0];
                        bus.table_code_width <= '0;
                        bus.table_data       <= {WIDTH_OUT{1'b0}};
                        next_addr            <= next_addr + ONE;
                        fill_active          <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_huffman_table_loader.sv
// Randomized scoreboard bench for huffman_table_loader: a set-level reference
// model predicts every table write, and a monitor checks them as they appear.
module tb_huffman_table_loader;
    localparam int W_OUT = 8;
    localparam int MAXL  = 9;
    localparam int LW    = $clog2(MAXL + 1);
    localparam int DEPTH = 1 << MAXL;

    typedef struct {
        int addr;
        int cw;
        int data;
    } wr_t;

    logic clk;
    logic rst;
    logic start;
    logic busy;
    logic done;
    logic incomplete;
    logic error;

    huffman_table_loader_if #(
        .WIDTH_OUT(W_OUT), .MAX_CODE_LENGTH(MAXL), .LOG2_MAX_CODE_LENGTH(LW)
    ) bus ();

    huffman_table_loader #(
        .WIDTH_OUT(W_OUT), .MAX_CODE_LENGTH(MAXL), .LOG2_MAX_CODE_LENGTH(LW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .bus(bus),
        .busy(busy),
        .done(done),
        .incomplete(incomplete),
        .error(error)
    );

    int  total = 0;
    int  bad   = 0;
    int  push_cnt;
    int  exp_writes;
    int  n_offer;
    bit  exp_done;
    bit  exp_inc;
    bit  exp_err;
    wr_t exp_q[$];
    int  set_sym[$];
    int  set_len[$];

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so a stuck build can never hang the run.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: pops one predicted write per observed table_push cycle.
    always @(negedge clk) begin
        wr_t e;
        if (bus.table_push) begin
            push_cnt++;
            check_output("in_ready_low_while_writing", int'(bus.in_ready), 0);
            if (exp_q.size() == 0) begin
                check_output("unexpected_write_addr", int'(bus.table_addr), -1);
            end else begin
                e = exp_q.pop_front();
                check_output("write_addr", int'(bus.table_addr), e.addr);
                check_output("write_code_width", int'(bus.table_code_width), e.cw);
                check_output("write_data", int'(bus.table_data), e.data);
            end
        end
    end

    // Reference model: walks the code set with plain arithmetic and predicts
    // every write, how many pairs get consumed, and the final flags.
    task automatic build_model();
        int addr;
        int prev;
        int span;
        wr_t w;
        addr     = 0;
        prev     = 0;
        exp_err  = 1'b0;
        exp_done = 1'b0;
        exp_inc  = 1'b0;
        n_offer  = set_len.size();
        for (int i = 0; i < set_len.size(); i++) begin
            if (set_len[i] == 0) continue;
            if (set_len[i] > MAXL || set_len[i] < prev) begin
                exp_err = 1'b1;
                n_offer = i + 1;
                break;
            end
            span = 1 << (MAXL - set_len[i]);
            if (addr + span > DEPTH) begin
                exp_err = 1'b1;
                n_offer = i + 1;
                break;
            end
            for (int k = 0; k < span; k++) begin
                w.addr = addr + k;
                w.cw   = set_len[i];
                w.data = set_sym[i];
                exp_q.push_back(w);
            end
            addr += span;
            prev  = set_len[i];
        end
        if (!exp_err) begin
            exp_done = 1'b1;
            exp_inc  = (addr < DEPTH);
            for (int a = addr; a < DEPTH; a++) begin
                w.addr = a;
                w.cw   = 0;
                w.data = 0;
                exp_q.push_back(w);
            end
        end
        exp_writes = exp_q.size();
    endtask

    // Offers one pair with random in_valid gaps until it is accepted.
    task automatic send_pair(input int sym, input int len, input bit last);
        bit got;
        int cycles;
        got    = 1'b0;
        cycles = 0;
        while (!got) begin
            @(negedge clk);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_symbol = W_OUT'(sym);
            bus.in_length = LW'(len);
            bus.in_last   = last;
            if (bus.in_valid && bus.in_ready) got = 1'b1;
            @(posedge clk);
            cycles++;
            if (!got && cycles > 3000) begin
                check_output("pair_accept_timeout", 0, 1);
                got = 1'b1;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output("start_clears_done", int'(done), 0);
        check_output("start_clears_error", int'(error), 0);
        check_output("start_sets_busy", int'(busy), 1);
    endtask

    // Runs one full build of the current set and checks its outcome.
    task automatic apply_stimulus(input string name);
        bit finished;
        $display("[TB] build %s: %0d pairs", name, set_len.size());
        exp_q.delete();
        build_model();
        push_cnt = 0;
        pulse_start();
        for (int i = 0; i < n_offer; i++)
            send_pair(set_sym[i], set_len[i], i == set_len.size() - 1);
        finished = 1'b0;
        for (int c = 0; c < 3000 && !finished; c++) begin
            @(negedge clk);
            if (done || error) finished = 1'b1;
        end
        check_output("build_finished", int'(finished), 1);
        repeat (4) @(negedge clk);
        check_output("done_flag", int'(done), int'(exp_done));
        check_output("incomplete_flag", int'(incomplete), int'(exp_inc));
        check_output("error_flag", int'(error), int'(exp_err));
        check_output("busy_after_build", int'(busy), 0);
        check_output("push_count", push_cnt, exp_writes);
        check_output("writes_left_over", exp_q.size(), 0);
    endtask

    initial begin
        rst           = 1'b0;
        start         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_symbol = '0;
        bus.in_length = '0;
        bus.in_last   = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_push", int'(bus.table_push), 0);
        check_output("reset_addr", int'(bus.table_addr), 0);
        check_output("reset_ready", int'(bus.in_ready), 0);
        check_output("reset_flags", int'({busy, done, incomplete, error}), 0);
        rst = 1'b1;
        @(negedge clk);

        set_sym = '{8'h41, 8'h42, 8'h43};  set_len = '{1, 2, 2};
        apply_stimulus("complete");
        set_sym = '{8'h07};                set_len = '{1};
        apply_stimulus("single_fill");
        set_sym = '{1, 2, 3};              set_len = '{1, 1, 1};
        apply_stimulus("oversubscribed");
        set_sym = '{4, 5};                 set_len = '{2, 1};
        apply_stimulus("bad_order");
        set_sym = '{6, 7};                 set_len = '{10, 1};
        apply_stimulus("len_too_long");
        set_sym = '{8'h01, 8'h02};         set_len = '{0, 9};
        apply_stimulus("skip_len0");
        set_sym = '{9, 10};                set_len = '{0, 0};
        apply_stimulus("all_unused");

        // Abort a build mid-write with reset, then rebuild from scratch.
        set_sym = '{8'h55, 8'h66};         set_len = '{1, 1};
        exp_q.delete();
        build_model();
        pulse_start();
        send_pair(8'h55, 1, 1'b0);
        for (int c = 0; c < 500; c++) begin
            if (bus.table_push && bus.table_addr == 100) break;
            @(negedge clk);
        end
        check_output("reached_addr_100", int'(bus.table_addr), 100);
        #2 rst = 1'b0;
        #1;
        check_output("abort_push", int'(bus.table_push), 0);
        check_output("abort_addr", int'(bus.table_addr), 0);
        check_output("abort_data", int'(bus.table_data), 0);
        check_output("abort_flags", int'({busy, done, error, bus.in_ready}), 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        apply_stimulus("after_reset");

        // Random code sets: mostly canonical runs, some shuffled garbage.
        for (int t = 0; t < 12; t++) begin
            int n;
            int len;
            n = $urandom_range(1, 5);
            set_sym.delete();
            set_len.delete();
            len = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                set_sym.push_back($urandom_range(0, 255));
                if (t % 4 == 3) begin
                    set_len.push_back($urandom_range(0, 10));
                end else if ($urandom_range(0, 5) == 0) begin
                    set_len.push_back(0);
                end else begin
                    set_len.push_back(len);
                    len += $urandom_range(0, 2);
                end
            end
            apply_stimulus("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
